// File: rtl/freq_ascii_tx_sequencer.sv
// Streams one measurement (nine ASCII digits D8..D0, then TERM_CHAR0/TERM_CHAR1) to a UART byte port.
// Optional leading-'0' suppression is enabled by defining LEADING_ZERO_SUPPRESS_EN.
module freq_ascii_tx_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  TERM_CHAR0    = 8'h0D,
    parameter logic [7:0]  TERM_CHAR1    = 8'h0A
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [71:0] Data_in,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_LOAD   = 3'd2,
        S_SEND   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PH_DIG = 2'd0,
        PH_T0  = 2'd1,
        PH_T1  = 2'd2,
        PH_END = 2'd3
    } phase_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    phase_t      r_phase;
    phase_t      w_phase_nxt;
    phase_t      w_phase;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  r_idx;
    logic [3:0]  w_idx_nxt;
    logic [3:0]  w_idx;
    logic [71:0] r_shift;
    logic [71:0] w_shift_nxt;
    logic [71:0] w_src;
    logic [7:0]  w_data_nxt;
    logic        w_valid_nxt;
    logic        w_overrun_nxt;
    logic        w_slot_free;
    logic        w_skip;

    // In LOAD the converter bus is used directly so D8 can be offered in the same cycle it is captured.
    assign w_src       = (r_state == S_LOAD) ? Data_in : r_shift;
    assign w_idx       = (r_state == S_LOAD) ? 4'd8 : r_idx;
    assign w_phase     = (r_state == S_LOAD) ? PH_DIG : r_phase;
    assign w_slot_free = !tx_valid || tx_ready;
    assign w_overrun_nxt = (start && (r_state != S_IDLE)) ? 1'b1 :
                           (start ? 1'b0 : overrun);

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic r_lead;
    logic w_lead_nxt;
    logic w_lead;

    assign w_lead = (r_state == S_LOAD) ? 1'b1 : r_lead;
    assign w_skip = w_lead && (w_src[71:64] == 8'h30) && (w_idx != 4'd0);

    // Leading-zero flag register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_lead <= 1'b0;
        end else begin
            r_lead <= w_lead_nxt;
        end
    end
`else
    assign w_skip = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath decode
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_idx_nxt   = w_idx;
        w_phase_nxt = w_phase;
        w_data_nxt  = tx_data;
        w_valid_nxt = tx_valid;
`ifdef LEADING_ZERO_SUPPRESS_EN
        w_lead_nxt  = w_lead;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_LAST) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            S_LOAD, S_SEND: begin
                w_state_nxt = S_SEND;
                if (w_slot_free) begin
                    case (w_phase)
                        PH_DIG: begin
                            w_shift_nxt = {w_src[63:0], 8'h00};
                            if (w_skip) begin
                                w_valid_nxt = 1'b0;
                                w_idx_nxt   = w_idx - 4'd1;
                            end else begin
                                w_data_nxt  = w_src[71:64];
                                w_valid_nxt = 1'b1;
`ifdef LEADING_ZERO_SUPPRESS_EN
                                w_lead_nxt  = 1'b0;
`endif
                                if (w_idx == 4'd0) begin
                                    w_phase_nxt = PH_T0;
                                end else begin
                                    w_idx_nxt = w_idx - 4'd1;
                                end
                            end
                        end
                        PH_T0: begin
                            w_data_nxt  = TERM_CHAR0;
                            w_valid_nxt = 1'b1;
                            w_phase_nxt = PH_T1;
                        end
                        PH_T1: begin
                            w_data_nxt  = TERM_CHAR1;
                            w_valid_nxt = 1'b1;
                            w_phase_nxt = PH_END;
                        end
                        default: begin
                            // TERM_CHAR1 has just been accepted
                            w_valid_nxt = 1'b0;
                            w_state_nxt = S_DONE;
                        end
                    endcase
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= 4'd0;
            r_idx    <= 4'd0;
            r_phase  <= PH_DIG;
            r_shift  <= 72'h0;
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_phase  <= w_phase_nxt;
            r_shift  <= w_shift_nxt;
            tx_data  <= w_data_nxt;
            tx_valid <= w_valid_nxt;
            busy     <= (w_state_nxt != S_IDLE);
            done     <= (w_state_nxt == S_DONE);
            overrun  <= w_overrun_nxt;
        end
    end

endmodule

// File: tb/tb_freq_ascii_tx_sequencer.sv
// Directed self-checking bench for freq_ascii_tx_sequencer (SETTLE_CYCLES = 2, CR/LF terminator).
module tb_freq_ascii_tx_sequencer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [71:0] Data_in;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
    logic        overrun;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    int         xfer_cyc[$];
    int         done_cyc;
    int         first_valid_cyc;
    logic       busy_at1;

    freq_ascii_tx_sequencer #(
        .SETTLE_CYCLES(2),
        .TERM_CHAR0(8'h0D),
        .TERM_CHAR1(8'h0A)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .start(start),
        .Data_in(Data_in),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    // Start edge is the second posedge; returns #1 after it.
    task automatic pulse_start(input logic [71:0] d);
        @(posedge CLK); #1;
        Data_in = d;
        start   = 1'b1;
        @(posedge CLK); #1;
        start   = 1'b0;
    endtask

    // Records transfers with their negedge index relative to the start edge.
    task automatic collect(input int budget);
        rx_q.delete();
        xfer_cyc.delete();
        done_cyc        = -1;
        first_valid_cyc = -1;
        busy_at1        = 1'b0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge CLK);
            if (i == 1) busy_at1 = busy;
            if (tx_valid && first_valid_cyc < 0) first_valid_cyc = i;
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                xfer_cyc.push_back(i);
            end
            if (done) begin
                done_cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        RST = 1'b1; start = 1'b0; tx_ready = 1'b1; Data_in = 72'h0;
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        RST = 1'b0;
        @(negedge CLK);
        n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid_rel: got %b expected 0", tx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    endtask

    task automatic test_full_frame;
        logic [7:0] exp_q[$];
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h0D, 8'h0A};
        tx_ready = 1'b1;
        pulse_start("123456789");
        collect(60);
        n_checks++; if (busy_at1 !== 1'b1) begin n_fail++; $display("FAIL full_busy_t1: got %b expected 1", busy_at1); end
        n_checks++; if (first_valid_cyc !== 4) begin n_fail++; $display("FAIL full_first_valid: got cycle %0d expected 4", first_valid_cyc); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        if (xfer_cyc.size() > 0) begin
            n_checks++; if (xfer_cyc[$] - xfer_cyc[0] !== xfer_cyc.size() - 1) begin n_fail++; $display("FAIL full_consecutive: span %0d expected %0d", xfer_cyc[$] - xfer_cyc[0], xfer_cyc.size() - 1); end
        end
        n_checks++; if (done_cyc !== 15) begin n_fail++; $display("FAIL full_done_cycle: got %0d expected 15", done_cyc); end
        @(negedge CLK);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL full_busy_fall: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_leading_zeros;
        logic [7:0] exp_q[$];
        int         exp_first;
`ifdef LEADING_ZERO_SUPPRESS_EN
        exp_q = '{8'h34, 8'h32, 8'h0D, 8'h0A};
        exp_first = 11;
`else
        exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};
        exp_first = 4;
`endif
        tx_ready = 1'b1;
        pulse_start("000000042");
        collect(60);
        n_checks++; if (first_valid_cyc !== exp_first) begin n_fail++; $display("FAIL lz42_first_valid: got %0d expected %0d", first_valid_cyc, exp_first); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL lz42_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lz42_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (done_cyc !== (xfer_cyc.size() > 0 ? xfer_cyc[$] + 1 : -2)) begin n_fail++; $display("FAIL lz42_done: got cycle %0d expected one after last transfer", done_cyc); end
        @(negedge CLK);
    endtask

    task automatic test_all_zeros;
        logic [7:0] exp_q[$];
        int         exp_first;
`ifdef LEADING_ZERO_SUPPRESS_EN
        exp_q = '{8'h30, 8'h0D, 8'h0A};
        exp_first = 12;
`else
        exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        exp_first = 4;
`endif
        tx_ready = 1'b1;
        pulse_start("000000000");
        collect(60);
        n_checks++; if (first_valid_cyc !== exp_first) begin n_fail++; $display("FAIL zero_first_valid: got %0d expected %0d", first_valid_cyc, exp_first); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL zero_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL zero_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL zero_done: got no done pulse expected one"); end
        @(negedge CLK);
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_q[$];
        int         stall_bad;
        logic       stalled;
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h0D, 8'h0A};
        tx_ready = 1'b1; stalled = 1'b0; stall_bad = 0; done_cyc = -1;
        rx_q.delete();
        pulse_start("123456789");
        for (int i = 1; i <= 80; i++) begin
            @(posedge CLK); #1;
            if (!stalled && tx_valid && tx_data == 8'h35) begin
                tx_ready = 1'b0;
                stalled  = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    @(negedge CLK);
                    if (!(tx_valid === 1'b1 && tx_data === 8'h35)) stall_bad++;
                    @(posedge CLK); #1;
                end
                tx_ready = 1'b1;
            end
            @(negedge CLK);
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (done) begin
                done_cyc = i;
                break;
            end
        end
        n_checks++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL bp_saw_35: got %b expected 1", stalled); end
        n_checks++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d unstable stall cycles expected 0", stall_bad); end
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (done_cyc < 0) begin n_fail++; $display("FAIL bp_done: got no done pulse expected one"); end
        @(negedge CLK);
    endtask

    task automatic test_overrun;
        logic [7:0] exp_q[$];
        exp_q = '{8'h39, 8'h38, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31, 8'h0D, 8'h0A};
        tx_ready = 1'b1; done_cyc = -1;
        rx_q.delete();
        pulse_start("987654321");
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (done) begin
                done_cyc = i;
                break;
            end
            start = (i == 6);
            if (i == 6) Data_in = "111111111";
        end
        start = 1'b0;
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL ovr_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ovr_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag_set: got %b expected 1", overrun); end
        @(negedge CLK);
        n_checks++; if (overrun !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ovr_sticky_idle: got overrun=%b busy=%b expected 1 0", overrun, busy); end
        pulse_start("555555555");
        @(negedge CLK);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_flag_clear: got %b expected 0", overrun); end
        collect(60);
        n_checks++; if (rx_q.size() !== 11) begin n_fail++; $display("FAIL ovr_next_frame: got %0d bytes expected 11", rx_q.size()); end
        @(negedge CLK);
    endtask

    task automatic test_reset_midframe;
        logic [7:0] exp_q[$];
        int         leak;
        exp_q = '{8'h32, 8'h34, 8'h36, 8'h38, 8'h31, 8'h33, 8'h35, 8'h37, 8'h39, 8'h0D, 8'h0A};
        tx_ready = 1'b1; leak = 0;
        rx_q.delete();
        pulse_start("246813579");
        for (int i = 1; i <= 60; i++) begin
            @(negedge CLK);
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (rx_q.size() == 4) break;
        end
        n_checks++; if (rx_q.size() !== 4) begin n_fail++; $display("FAIL rstmid_reach4: got %0d bytes expected 4", rx_q.size()); end
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        n_checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rstmid_tx: got valid=%b data=%h expected 0 00", tx_valid, tx_data); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got busy=%b done=%b overrun=%b expected 0 0 0", busy, done, overrun); end
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (tx_valid || busy || done) leak++;
        end
        n_checks++; if (leak !== 0) begin n_fail++; $display("FAIL rstmid_no_resume: got %0d active cycles expected 0", leak); end
        pulse_start("246813579");
        collect(60);
        n_checks++; if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d expected %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_checks++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rstmid_byte%0d: got %h expected %h", i, rx_q[i], exp_q[i]); end
        end
        n_checks++; if (done_cyc !== 15) begin n_fail++; $display("FAIL rstmid_done_cycle: got %0d expected 15", done_cyc); end
        @(negedge CLK);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_leading_zeros();
        test_all_zeros();
        test_backpressure();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
